// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
//
// Serial frame receiver with XOR parity check. This is the decoding end of the
// XOR parity generator. The serial line is sampled only on cycles where the
// external bit strobe is high. One frame is:
//   start (0), DATA_W data bits LSB first, parity bit, stop (1)
// Each completed frame produces a one-cycle valid pulse. The data word and the
// error flags are updated with that pulse and hold until the next one.
//
// Parameters:
//   DATA_W      data bits per frame (1..16)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         serial line, idles high
//   bit_en      one-cycle sample strobe for din
//   data_out    last received data word
//   valid       one-cycle pulse: frame complete, outputs updated
//   parity_err  last frame failed the parity check
//   frame_err   last frame had a stop bit of 0
//   busy        a frame is in progress
// -----------------------------------------------------------------------------
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // One extra bit so the counter never wraps, even at DATA_W = 16.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              acc_q,   acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q,  perr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic              pe_q,    pe_d;
    logic              fe_q,    fe_d;

    // The error is flagged when the data bits and the received parity bit do
    // not XOR to the selected sense.
    function automatic logic parity_error(input logic acc, input logic pbit);
        return acc ^ pbit ^ ODD_BIT;
    endfunction

    // Next-state logic. Without a strobe, every register holds its value.
    // The one exception is valid, which is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        valid_d = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    // The position is written directly. This keeps the word
                    // LSB-first without any final bit reversal.
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = din;
                        end
                    end
                    acc_d = acc_q ^ din;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    perr_d  = parity_error(acc_q, din);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit is only reported. The receiver makes no
                    // attempt to resynchronise; the next low sample is taken
                    // as a start bit.
                    data_d  = shift_q;
                    pe_d    = perr_q;
                    fe_d    = ~din;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_rx
//
// Drives serial frames into two receivers that share the same line: one
// configured for even parity and one for odd parity. The expected word and
// flags for each frame are computed from the frame contents.
// -----------------------------------------------------------------------------
module tb_serial_parity_rx;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b1;
    logic bit_en = 1'b0;

    logic [DW-1:0] data_e, data_o;
    logic          valid_e, valid_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

    serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst(rst), .din(din), .bit_en(bit_en),
        .data_out(data_e), .valid(valid_e), .parity_err(pe_e),
        .frame_err(fe_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .din(din), .bit_en(bit_en),
        .data_out(data_o), .valid(valid_o), .parity_err(pe_o),
        .frame_err(fe_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
        logic          pe_odd;
        logic          v_odd;
        int            cyc;
    } obs_t;

    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor state. Only the monitor writes these.
    int   cyc = 0;
    int   vld_cnt = 0;
    int   busy_cnt = 0;
    int   dbl_cnt = 0;
    logic prev_v = 1'b0;
    obs_t obs [256];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy_e) busy_cnt = busy_cnt + 1;
        if (valid_e && prev_v) dbl_cnt = dbl_cnt + 1;
        prev_v = valid_e;
        if (valid_e && vld_cnt < 256) begin
            obs[vld_cnt] = '{data_e, pe_e, fe_e, pe_o, valid_o, cyc};
            vld_cnt = vld_cnt + 1;
        end
    end

    // One strobe, preceded by a gap of idle (bit_en=0) cycles.
    task automatic strobe(input logic b, input int gap);
        bit_en = 1'b0;
        repeat (gap) @(negedge clk);
        din    = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic p,
                              input logic s, input int maxgap);
        strobe(1'b0, pick_gap(maxgap));
        for (int i = 0; i < DW; i++) strobe(d[i], pick_gap(maxgap));
        strobe(p, pick_gap(maxgap));
        strobe(s, pick_gap(maxgap));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({data_e, valid_e, pe_e, fe_e, busy_e} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
                     data_e, valid_e, pe_e, fe_e, busy_e);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_even_clean;
        int base = vld_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        n_cmp++;
        if (busy_e !== 1'b0) begin
            n_bad++;
            $display("FAIL even_busy_after_stop: got %b want 0", busy_e);
        end
        @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL even_valid_count: got %0d want 1", vld_cnt - base);
        end else begin
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe} !== {8'hA5, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL even_frame: got d=%h pe=%b fe=%b want d=a5 pe=0 fe=0",
                         obs[base].d, obs[base].pe, obs[base].fe);
            end
        end
    endtask

    task automatic test_parity_err;
        int base = vld_cnt;
        send_frame(8'h01, 1'b0, 1'b1, 1);
        @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL perr_valid_count: got %0d want 1", vld_cnt - base);
        end else begin
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe} !== {8'h01, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL perr_even: got d=%h pe=%b fe=%b want d=01 pe=1 fe=0",
                         obs[base].d, obs[base].pe, obs[base].fe);
            end
            n_cmp++;
            if ({obs[base].v_odd, obs[base].pe_odd} !== 2'b10) begin
                n_bad++;
                $display("FAIL perr_odd_mode: got v=%b pe=%b want v=1 pe=0",
                         obs[base].v_odd, obs[base].pe_odd);
            end
        end
    endtask

    task automatic test_frame_err;
        int base = vld_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        send_frame(8'h55, 1'b0, 1'b1, 2);
        @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 2) begin
            n_bad++;
            $display("FAIL ferr_valid_count: got %0d want 2", vld_cnt - base);
        end else begin
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe} !== {8'h3C, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL ferr_frame: got d=%h pe=%b fe=%b want d=3c pe=0 fe=1",
                         obs[base].d, obs[base].pe, obs[base].fe);
            end
            n_cmp++;
            if ({obs[base+1].d, obs[base+1].pe, obs[base+1].fe} !== {8'h55, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL ferr_recover: got d=%h pe=%b fe=%b want d=55 pe=0 fe=0",
                         obs[base+1].d, obs[base+1].pe, obs[base+1].fe);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int base = vld_cnt;
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({data_e, valid_e, pe_e, fe_e, busy_e} !== '0) begin
            n_bad++;
            $display("FAIL midreset_state: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
                     data_e, valid_e, pe_e, fe_e, busy_e);
        end
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL midreset_valid_count: got %0d want 1", vld_cnt - base);
        end else begin
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe} !== {8'hF0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL midreset_frame: got d=%h pe=%b fe=%b want d=f0 pe=0 fe=0",
                         obs[base].d, obs[base].pe, obs[base].fe);
            end
        end
    endtask

    task automatic test_gaps_noise;
        int base  = vld_cnt;
        int bbase = busy_cnt;
        for (int i = 0; i < 20; i++) strobe(1'b1, i % 3);
        @(negedge clk);
        n_cmp++;
        if ((busy_cnt - bbase) !== 0 || (vld_cnt - base) !== 0) begin
            n_bad++;
            $display("FAIL idle_noise: got busy cycles=%0d valids=%0d want 0 and 0",
                     busy_cnt - bbase, vld_cnt - base);
        end
        send_frame(8'h81, 1'b0, 1'b1, 5);
        @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL gaps_valid_count: got %0d want 1", vld_cnt - base);
        end else begin
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe} !== {8'h81, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL gaps_frame: got d=%h pe=%b fe=%b want d=81 pe=0 fe=0",
                         obs[base].d, obs[base].pe, obs[base].fe);
            end
        end
    endtask

    task automatic test_back_to_back;
        int base = vld_cnt;
        logic [DW-1:0] a = 8'h12;
        logic [DW-1:0] b = 8'h34;
        send_frame(a, ^a, 1'b1, 0);
        send_frame(b, ^b, 1'b1, 0);
        @(negedge clk);
        n_cmp++;
        if (vld_cnt - base !== 2) begin
            n_bad++;
            $display("FAIL b2b_valid_count: got %0d want 2", vld_cnt - base);
        end else begin
            n_cmp++;
            if (obs[base+1].cyc - obs[base].cyc !== DW + 3) begin
                n_bad++;
                $display("FAIL b2b_spacing: got %0d cycles want %0d",
                         obs[base+1].cyc - obs[base].cyc, DW + 3);
            end
            n_cmp++;
            if ({obs[base].d, obs[base].pe, obs[base].fe,
                 obs[base+1].d, obs[base+1].pe, obs[base+1].fe}
                !== {a, 1'b0, 1'b0, b, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_frames: got %h/%b%b %h/%b%b want 12/00 34/00",
                         obs[base].d, obs[base].pe, obs[base].fe,
                         obs[base+1].d, obs[base+1].pe, obs[base+1].fe);
            end
        end
    endtask

    // Random frames. Each expected flag comes straight from the frame rules:
    // the parity error is the XOR of all data bits, the parity bit and the
    // odd/even sense, and the framing error is a stop bit of 0.
    task automatic test_random;
        for (int k = 0; k < 30; k++) begin
            int            base = vld_cnt;
            logic [DW-1:0] d    = DW'($urandom);
            logic          p    = ($urandom_range(3, 0) == 0) ? ~(^d) : (^d);
            logic          s    = ($urandom_range(4, 0) != 0);
            logic          exp_pe_even = (^d) ^ p;
            logic          exp_pe_odd  = ~((^d) ^ p);
            logic          exp_fe      = ~s;
            send_frame(d, p, s, 3);
            @(negedge clk);
            n_cmp++;
            if (vld_cnt - base !== 1) begin
                n_bad++;
                $display("FAIL rand_valid_count[%0d]: got %0d want 1", k, vld_cnt - base);
            end else begin
                n_cmp++;
                if ({obs[base].d, obs[base].pe, obs[base].fe, obs[base].pe_odd}
                    !== {d, exp_pe_even, exp_fe, exp_pe_odd}) begin
                    n_bad++;
                    $display("FAIL rand_frame[%0d]: got d=%h pe=%b fe=%b peo=%b want d=%h pe=%b fe=%b peo=%b",
                             k, obs[base].d, obs[base].pe, obs[base].fe, obs[base].pe_odd,
                             d, exp_pe_even, exp_fe, exp_pe_odd);
                end
            end
        end
    endtask

    task automatic test_valid_width;
        n_cmp++;
        if (dbl_cnt !== 0) begin
            n_bad++;
            $display("FAIL valid_one_cycle: got %0d multi-cycle pulses want 0", dbl_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_even_clean;
        test_parity_err;
        test_frame_err;
        test_reset_midframe;
        test_gaps_noise;
        test_back_to_back;
        test_random;
        test_valid_width;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver with XOR parity check: the decoding end of the team's XOR-based parity generator. It samples a single-bit serial line on an external bit strobe and deserialises a frame of start, data, parity and stop bits. It presents the data word with parity-error and framing-error flags. It sits between the serial link input and the word-level consumer logic.

## Interface

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1..16)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- din  input  1  serial line; idle level 1
- bit_en  input  1  one-cycle sample strobe; din is sampled only on cycles where bit_en=1
- data_out  output  DATA_W  last received data word, LSB first on the line
- valid  output  1  one-cycle pulse: frame complete, data_out and flags updated
- parity_err  output  1  last frame failed the parity check
- frame_err  output  1  last frame had stop bit = 0
- busy  output  1  1 while a frame is in progress (state != IDLE)

## Operation

- Frame on the line: start (0), DATA_W data bits LSB first, parity bit, stop (1). That is DATA_W+3 strobes per frame.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on cycles with bit_en=1. Every other cycle holds all state.
- IDLE:
  - bit_en & din=0 -> DATA; bit counter = 0; parity accumulator = 0.
  - bit_en & din=1 -> stay in IDLE.
- DATA:
  - On each bit_en, shift din into the shift register at bit position cnt (LSB first) and XOR din into the accumulator.
  - When cnt = DATA_W-1, go to PARITY; otherwise increment cnt.
  - The counter width is ceil(log2(DATA_W))+1 bits, so it does not wrap for DATA_W up to 16.
- PARITY:
  - On bit_en, latch the internal error: perr = acc ^ din ^ PARITY_ODD.
  - Then go to STOP.
- STOP:
  - On bit_en: data_out <= shift register; parity_err <= perr; frame_err <= ~din; valid <= 1; go to IDLE.
- valid is asserted for every completed frame, including frames with errors. The flags qualify the word.
- data_out, parity_err and frame_err hold their values until the next valid.
- A stop bit of 0 does not resynchronise the receiver. The FSM returns to IDLE, and the next bit_en with din=0 is treated as a new start bit.
- No break detection and no start-bit revalidation.

## Timing

- Reset (rst=1 at a rising edge): state=IDLE, cnt=0, acc=0, data_out=0, valid=0, parity_err=0, frame_err=0, busy=0.
- Reset takes priority over bit_en in the same cycle.
- Reset mid-frame discards the partial frame and produces no valid pulse.
- busy goes high on the edge that samples the start bit. It goes low on the edge that samples the stop bit.
- valid is registered high on the edge that samples the stop bit. It is high for exactly one clk cycle, then low, regardless of bit_en.
- Latency: valid appears DATA_W+3 bit_en strobes after the start-bit strobe is counted as strobe 1. For DATA_W=8, that is strobe 11.
- Back-to-back frames: the strobe immediately after the stop strobe may be the next start bit. No idle strobe is required.
- Consecutive bit_en strobes (bit_en held at 1) are legal. Full throughput is one bit per clk.
- Gaps of any length between strobes do not affect the result.

## Test plan

- Even parity, DATA_W=8: send 0xA5, parity=0, stop=1 -> one valid pulse; data_out=0xA5; parity_err=0; frame_err=0; busy low after the stop strobe.
- Parity error: send 0x01 with parity=0 (even mode) -> valid; data_out=0x01; parity_err=1; frame_err=0.
  - Repeat with PARITY_ODD=1, parity=0 -> parity_err=0.
- Framing error: send 0x3C, parity=0, stop=0 -> valid; data_out=0x3C; frame_err=1; parity_err=0.
  - A following clean frame 0x55 -> frame_err returns to 0.
- Reset mid-frame: after start plus 4 data bits, assert rst for 1 cycle, then send a full 0xF0 frame -> exactly one valid, data_out=0xF0, all outputs 0 in the cycle after reset.
- Strobe gaps and idle noise:
  - Hold din=1 with 20 strobes -> no busy, no valid.
  - Then send 0x81 with random 0–5 cycle gaps between strobes -> data_out=0x81, no errors.
- Back-to-back: send 0x12 and 0x34 with bit_en held high continuously -> two valid pulses 11 cycles apart, data 0x12 then 0x34, no errors.
